// File: rtl/irq_source_ctrl_if.sv
// Configuration bus for irq_source_ctrl: write strobe/address/data in,
// registered read data out.
interface irq_source_ctrl_if;
    logic        cfg_wen;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_wen, cfg_addr, cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_wen, cfg_addr, cfg_wdata,
        output cfg_rdata
    );
endinterface

// File: rtl/irq_source_ctrl.sv
// Interrupt source front-end: synchronises external IRQ lines, applies
// edge/level mode and mask, and runs a down-counting timer on line 0.
module irq_source_ctrl #(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic [NUM_IRQ-2:0]  irq_raw,
    irq_source_ctrl_if.slave    cfg,
    output logic [NUM_IRQ-1:0]  interrupts,
    output logic [TIMER_W-1:0]  timer_count
);

    localparam int NUM_EXT = NUM_IRQ - 1;
    localparam logic [TIMER_W-1:0] COUNT_ONE = TIMER_W'(1);

    typedef enum logic [1:0] {
        ADDR_MODE   = 2'd0,
        ADDR_MASK   = 2'd1,
        ADDR_RELOAD = 2'd2,
        ADDR_TCTRL  = 2'd3
    } cfg_addr_t;

    logic [SYNC_STAGES-1:0][NUM_EXT-1:0] sync_pipe;
    logic [NUM_EXT-1:0] sync_line;
    logic [NUM_EXT-1:0] prev_line;
    logic [NUM_EXT-1:0] req;
    logic [NUM_EXT-1:0] mode_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [TIMER_W-1:0] reload_q;
    logic [TIMER_W-1:0] count_q;
    logic               en_q;
    logic               oneshot_q;
    logic               tick;
    logic [31:0]        rdata_next;

    // Synchronisers and edge history run unconditionally so that mask or
    // mode changes never see stale samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe <= '0;
            prev_line <= '0;
        end else begin
            sync_pipe[0] <= irq_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= sync_pipe[s-1];
            end
            prev_line <= sync_line;
        end
    end

    assign sync_line   = sync_pipe[SYNC_STAGES-1];
    assign req         = (mode_q & sync_line & ~prev_line) | (~mode_q & sync_line);
    assign tick        = en_q & clk_en;
    assign timer_count = count_q;

    always_comb begin
        rdata_next = '0;
        case (cfg_addr_t'(cfg.cfg_addr))
            ADDR_MODE:   rdata_next[NUM_IRQ-1:0] = {mode_q, 1'b0};
            ADDR_MASK:   rdata_next[NUM_IRQ-1:0] = mask_q;
            ADDR_RELOAD: rdata_next[TIMER_W-1:0] = reload_q;
            ADDR_TCTRL:  rdata_next[1:0]         = {oneshot_q, en_q};
            default:     rdata_next              = '0;
        endcase
    end

    // Config writes are placed after the timer update so they win any
    // same-edge conflict with reload or the one-shot enable clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= '0;
            mask_q        <= '0;
            reload_q      <= '0;
            count_q       <= '0;
            en_q          <= 1'b0;
            oneshot_q     <= 1'b0;
            interrupts    <= '0;
            cfg.cfg_rdata <= '0;
        end else begin
            interrupts[NUM_IRQ-1:1] <= req & mask_q[NUM_IRQ-1:1];
            interrupts[0]           <= 1'b0;
            cfg.cfg_rdata           <= rdata_next;

            if (tick) begin
                if (count_q != '0) begin
                    count_q <= count_q - COUNT_ONE;
                end else begin
                    interrupts[0] <= mask_q[0];
                    count_q       <= reload_q;
                    if (oneshot_q) begin
                        en_q <= 1'b0;
                    end
                end
            end

            if (cfg.cfg_wen) begin
                case (cfg_addr_t'(cfg.cfg_addr))
                    ADDR_MODE:   mode_q <= cfg.cfg_wdata[NUM_IRQ-1:1];
                    ADDR_MASK:   mask_q <= cfg.cfg_wdata[NUM_IRQ-1:0];
                    ADDR_RELOAD: begin
                        reload_q <= cfg.cfg_wdata[TIMER_W-1:0];
                        count_q  <= cfg.cfg_wdata[TIMER_W-1:0];
                    end
                    ADDR_TCTRL: begin
                        en_q      <= cfg.cfg_wdata[0];
                        oneshot_q <= cfg.cfg_wdata[1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed self-checking bench for irq_source_ctrl.
module tb_irq_source_ctrl;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [14:0] irq_raw;
    logic [15:0] interrupts;
    logic [31:0] timer_count;
    int          n_compared;
    int          n_mismatched;

    irq_source_ctrl_if cfg_bus ();

    irq_source_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .irq_raw     (irq_raw),
        .cfg         (cfg_bus),
        .interrupts  (interrupts),
        .timer_count (timer_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns 1 time unit after a rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_bus.cfg_wen   = 1'b1;
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_wdata = d;
        tick();
        cfg_bus.cfg_wen   = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        irq_raw = 15'h7FFF;
        repeat (3) tick();
        n_compared++;
        if (interrupts !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_interrupts got=%h want=%h", interrupts, 16'h0000);
        end
        n_compared++;
        if (cfg_bus.cfg_rdata !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_rdata got=%h want=%h", cfg_bus.cfg_rdata, 32'h0);
        end
        n_compared++;
        if (timer_count !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_count got=%h want=%h", timer_count, 32'h0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_compared++;
            if (interrupts !== 16'h0000) begin
                n_mismatched++;
                $display("[TB] FAIL masked_after_reset c=%0d got=%h want=%h", c, interrupts, 16'h0000);
            end
        end
        irq_raw = '0;
        repeat (4) tick();
    endtask

    task automatic test_edge();
        logic [15:0] exp;
        cfg_write(2'd1, 32'h0000_0002);
        cfg_write(2'd0, 32'hFFFF_FFFF);
        tick();
        n_compared++;
        if (cfg_bus.cfg_rdata !== 32'h0000_FFFE) begin
            n_mismatched++;
            $display("[TB] FAIL mode_readback got=%h want=%h", cfg_bus.cfg_rdata, 32'h0000_FFFE);
        end
        cfg_write(2'd0, 32'h0000_0002);
        irq_raw = 15'h0001;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = (c == 3) ? 16'h0002 : 16'h0000;
            n_compared++;
            if (interrupts !== exp) begin
                n_mismatched++;
                $display("[TB] FAIL edge_line1 c=%0d got=%h want=%h", c, interrupts, exp);
            end
        end
        irq_raw = '0;
        repeat (4) tick();
    endtask

    task automatic test_level();
        logic [15:0] exp;
        cfg_write(2'd1, 32'h0000_0004);
        cfg_write(2'd0, 32'h0000_0000);
        irq_raw = 15'h0002;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 5) irq_raw = '0;
            exp = (c >= 3 && c <= 7) ? 16'h0004 : 16'h0000;
            n_compared++;
            if (interrupts !== exp) begin
                n_mismatched++;
                $display("[TB] FAIL level_line2 c=%0d got=%h want=%h", c, interrupts, exp);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_unmask();
        cfg_write(2'd1, 32'h0);
        cfg_write(2'd0, 32'h0);
        irq_raw = 15'h0010;
        repeat (4) tick();
        cfg_write(2'd1, 32'h0000_0020);
        n_compared++;
        if (interrupts !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL unmask_same_edge got=%h want=%h", interrupts, 16'h0000);
        end
        tick();
        n_compared++;
        if (interrupts !== 16'h0020) begin
            n_mismatched++;
            $display("[TB] FAIL unmask_level got=%h want=%h", interrupts, 16'h0020);
        end
        cfg_write(2'd0, 32'h0000_0020);
        tick();
        n_compared++;
        if (interrupts !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL edge_while_high got=%h want=%h", interrupts, 16'h0000);
        end
        irq_raw = '0;
        repeat (4) tick();
        cfg_write(2'd1, 32'h0);
        cfg_write(2'd0, 32'h0);
    endtask

    task automatic test_timer_periodic();
        logic [31:0] exp_cnt [8] = '{32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
        logic [15:0] exp;
        clk_en = 1'b1;
        cfg_write(2'd2, 32'd3);
        cfg_write(2'd1, 32'h0000_0001);
        cfg_write(2'd3, 32'h0000_0001);
        n_compared++;
        if (timer_count !== 32'd3) begin
            n_mismatched++;
            $display("[TB] FAIL timer_start got=%0d want=%0d", timer_count, 3);
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = (c == 4 || c == 8) ? 16'h0001 : 16'h0000;
            n_compared++;
            if (timer_count !== exp_cnt[c-1] || interrupts !== exp) begin
                n_mismatched++;
                $display("[TB] FAIL timer_run c=%0d got cnt=%0d irq=%h want cnt=%0d irq=%h",
                         c, timer_count, interrupts, exp_cnt[c-1], exp);
            end
        end
        clk_en = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_compared++;
            if (timer_count !== 32'd3 || interrupts !== 16'h0000) begin
                n_mismatched++;
                $display("[TB] FAIL timer_frozen c=%0d got cnt=%0d irq=%h want cnt=3 irq=0000",
                         c, timer_count, interrupts);
            end
        end
        clk_en = 1'b1;
        tick();
        n_compared++;
        if (timer_count !== 32'd2) begin
            n_mismatched++;
            $display("[TB] FAIL timer_resume got=%0d want=%0d", timer_count, 2);
        end
        cfg_write(2'd3, 32'h0);
        tick();
        n_compared++;
        if (timer_count !== 32'd1) begin
            n_mismatched++;
            $display("[TB] FAIL timer_disabled got=%0d want=%0d", timer_count, 1);
        end
    endtask

    task automatic test_oneshot();
        cfg_write(2'd2, 32'd1);
        cfg_write(2'd3, 32'h0000_0003);
        tick();
        n_compared++;
        if (timer_count !== 32'd0 || interrupts !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL oneshot_t1 got cnt=%0d irq=%h want cnt=0 irq=0000", timer_count, interrupts);
        end
        tick();
        n_compared++;
        if (timer_count !== 32'd1 || interrupts !== 16'h0001) begin
            n_mismatched++;
            $display("[TB] FAIL oneshot_fire got cnt=%0d irq=%h want cnt=1 irq=0001", timer_count, interrupts);
        end
        cfg_bus.cfg_addr = 2'd3;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_compared++;
            if (timer_count !== 32'd1 || interrupts !== 16'h0000) begin
                n_mismatched++;
                $display("[TB] FAIL oneshot_stopped c=%0d got cnt=%0d irq=%h want cnt=1 irq=0000",
                         c, timer_count, interrupts);
            end
        end
        n_compared++;
        if (cfg_bus.cfg_rdata !== 32'h0000_0002) begin
            n_mismatched++;
            $display("[TB] FAIL oneshot_tctrl got=%h want=%h", cfg_bus.cfg_rdata, 32'h0000_0002);
        end
    endtask

    task automatic test_back_to_back();
        cfg_write(2'd2, 32'd1);
        cfg_write(2'd3, 32'h0000_0003);
        tick();
        cfg_write(2'd3, 32'h0000_0001);
        n_compared++;
        if (interrupts !== 16'h0001 || timer_count !== 32'd1) begin
            n_mismatched++;
            $display("[TB] FAIL fire_with_write got irq=%h cnt=%0d want irq=0001 cnt=1", interrupts, timer_count);
        end
        n_compared++;
        if (cfg_bus.cfg_rdata !== 32'h0000_0003) begin
            n_mismatched++;
            $display("[TB] FAIL read_old_tctrl got=%h want=%h", cfg_bus.cfg_rdata, 32'h0000_0003);
        end
        tick();
        n_compared++;
        if (cfg_bus.cfg_rdata !== 32'h0000_0001 || timer_count !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL en_kept got rdata=%h cnt=%0d want rdata=00000001 cnt=0", cfg_bus.cfg_rdata, timer_count);
        end
        tick();
        n_compared++;
        if (interrupts !== 16'h0001 || timer_count !== 32'd1) begin
            n_mismatched++;
            $display("[TB] FAIL periodic_after got irq=%h cnt=%0d want irq=0001 cnt=1", interrupts, timer_count);
        end
        rst = 1'b1;
        tick();
        n_compared++;
        if (interrupts !== 16'h0000 || timer_count !== 32'd0 || cfg_bus.cfg_rdata !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset got irq=%h cnt=%0d rdata=%h want all zero",
                     interrupts, timer_count, cfg_bus.cfg_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        n_compared        = 0;
        n_mismatched      = 0;
        rst               = 1'b1;
        clk_en            = 1'b0;
        irq_raw           = '0;
        cfg_bus.cfg_wen   = 1'b0;
        cfg_bus.cfg_addr  = 2'd0;
        cfg_bus.cfg_wdata = 32'h0;

        test_reset();
        test_edge();
        test_level();
        test_unmask();
        test_timer_periodic();
        test_oneshot();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
